// File: rtl/data_gen_pkg.sv
// Shared constants for the burst pattern generator: pattern modes and FSM encoding.
package data_gen_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RAMP   = 2'd0;
  localparam mode_t MODE_CNT    = 2'd1;
  localparam mode_t MODE_CONST  = 2'd2;
  localparam mode_t MODE_TOGGLE = 2'd3;

  // Two bits so that a corrupted state value has somewhere defined to go.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

endpackage

// File: rtl/data_gen_pattern.sv
// Pattern next-state logic: beat-0 word for a mode/seed and the successor of the current word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to advance.
module data_gen_pattern
  import data_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] cur_word,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              odd_beat,
  output logic [DATA_W-1:0] first_word,
  output logic [DATA_W-1:0] next_word
);

  localparam int N = DATA_W / 8;

  logic [DATA_W-1:0] ramp_first;
  logic [DATA_W-1:0] ramp_next;

  // Lane 0 is the LSB byte and carries the highest ramp value of the beat.
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      assign ramp_first[8*g +: 8] = 8'(N - 1 - g);
      assign ramp_next[8*g +: 8]  = cur_word[8*g +: 8] + 8'(N);
    end
  endgenerate

  always_comb begin
    first_word = seed;
    next_word  = cur_word;
    case (mode)
      MODE_RAMP: begin
        first_word = ramp_first;
        next_word  = ramp_next;
      end
      MODE_CNT: begin
        first_word = seed;
        next_word  = cur_word + {{(DATA_W-1){1'b0}}, 1'b1};
      end
      MODE_CONST: begin
        first_word = seed;
        next_word  = seed;
      end
      default: begin
        // odd_beat describes the current beat, so the next one flips parity.
        first_word = seed;
        next_word  = odd_beat ? seed : ~seed;
      end
    endcase
  end

endmodule

// File: rtl/burst_data_gen.sv
// Burst test-pattern source: on start emits len+1 beats of a selectable pattern.
// Latency: beat 0 valid the cycle after start; done pulses the cycle after the last transfer.
// Backpressure: data/last hold while valid && !ready; abort drops valid next cycle.
module burst_data_gen
  import data_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  logic [1:0]        state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  mode_t             mode_q;
  logic [DATA_W-1:0] seed_q;

  logic              idle;
  logic              xfer;
  logic              at_last;
  logic [LEN_W-1:0]  cnt_inc;
  mode_t             pat_mode;
  logic [DATA_W-1:0] pat_seed;
  logic [DATA_W-1:0] first_word;
  logic [DATA_W-1:0] next_word;

  assign idle    = (state == ST_IDLE);
  assign xfer    = valid_o & ready_i;
  assign at_last = (cnt == len_q);
  assign cnt_inc = cnt + {{(LEN_W-1){1'b0}}, 1'b1};

  // Beat 0 is built from the live inputs so it can be registered on the start cycle.
  assign pat_mode = idle ? mode_i : mode_q;
  assign pat_seed = idle ? seed_i : seed_q;

  data_gen_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .cur_word   (data_o),
    .mode       (pat_mode),
    .seed       (pat_seed),
    .odd_beat   (cnt[0]),
    .first_word (first_word),
    .next_word  (next_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      mode_q  <= MODE_RAMP;
      seed_q  <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state   <= ST_RUN;
            cnt     <= '0;
            len_q   <= len_i;
            mode_q  <= mode_i;
            seed_q  <= seed_i;
            data_o  <= first_word;
            valid_o <= 1'b1;
            last_o  <= (len_i == '0);
            busy_o  <= 1'b1;
          end
        end
        ST_RUN: begin
          // Abort wins over a coincident transfer: no done pulse is produced.
          if (abort_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            busy_o  <= 1'b0;
          end else if (xfer) begin
            if (at_last) begin
              state   <= ST_IDLE;
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              cnt    <= cnt_inc;
              data_o <= next_word;
              last_o <= (cnt_inc == len_q);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_o <= 1'b0;
          last_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_data_gen.sv
// Bench for burst_data_gen: three instances (32/8, 32/4, 64/8) behind one monitor mux.
module tb_burst_data_gen;

  typedef struct {
    logic [63:0] dat;
    logic        lst;
  } sb_t;

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    int          len;
    logic [63:0] seed;
    int          stall_beat;
    int          stall_len;
    int          poke_beat;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;
  logic [7:0]  len  = '0;
  logic [1:0]  mode = '0;
  logic [63:0] seed = '0;
  int sel = 0;
  int dw  = 32;

  int total = 0;
  int bad   = 0;
  sb_t sbq[$];

  always #5 clk = ~clk;

  logic start_a, start_b, start_c, abort_a, abort_b, abort_c;
  assign start_a = start & (sel == 0);
  assign start_b = start & (sel == 1);
  assign start_c = start & (sel == 2);
  assign abort_a = abort & (sel == 0);
  assign abort_b = abort & (sel == 1);
  assign abort_c = abort & (sel == 2);

  logic [31:0] data_a, data_b;
  logic [63:0] data_c;
  logic valid_a, valid_b, valid_c, last_a, last_b, last_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

  burst_data_gen #(.DATA_W(32), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a), .len_i(len),
    .mode_i(mode), .seed_i(seed[31:0]), .data_o(data_a), .valid_o(valid_a),
    .ready_i(ready), .last_o(last_a), .busy_o(busy_a), .done_o(done_a));

  burst_data_gen #(.DATA_W(32), .LEN_W(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b), .len_i(len[3:0]),
    .mode_i(mode), .seed_i(seed[31:0]), .data_o(data_b), .valid_o(valid_b),
    .ready_i(ready), .last_o(last_b), .busy_o(busy_b), .done_o(done_b));

  burst_data_gen #(.DATA_W(64), .LEN_W(8)) dut_c (
    .clk(clk), .rst(rst), .start_i(start_c), .abort_i(abort_c), .len_i(len),
    .mode_i(mode), .seed_i(seed), .data_o(data_c), .valid_o(valid_c),
    .ready_i(ready), .last_o(last_c), .busy_o(busy_c), .done_o(done_c));

  logic [63:0] mon_data;
  logic mon_valid, mon_last, mon_busy, mon_done;

  always_comb begin
    mon_data  = {32'h0, data_a};
    mon_valid = valid_a;
    mon_last  = last_a;
    mon_busy  = busy_a;
    mon_done  = done_a;
    if (sel == 1) begin
      mon_data  = {32'h0, data_b};
      mon_valid = valid_b;
      mon_last  = last_b;
      mon_busy  = busy_b;
      mon_done  = done_b;
    end else if (sel == 2) begin
      mon_data  = data_c;
      mon_valid = valid_c;
      mon_last  = last_c;
      mon_busy  = busy_c;
      mon_done  = done_c;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pattern for beat k, written from the beat-index formulas.
  function automatic logic [63:0] beat_val(input logic [1:0] m, input logic [63:0] s,
                                           input int k, input int w);
    logic [63:0] r;
    logic [63:0] mask;
    int n;
    r    = '0;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    n    = w / 8;
    case (m)
      2'd0: for (int b = 0; b < n; b++) r[8*b +: 8] = 8'((n*k + n - 1 - b) % 256);
      2'd1: r = (s + 64'(k)) & mask;
      2'd2: r = s & mask;
      default: r = (((k % 2) == 1) ? ~s : s) & mask;
    endcase
    return r;
  endfunction

  task automatic do_start(input logic [1:0] m, input int l, input logic [63:0] s);
    sb_t e;
    for (int k = 0; k <= l; k++) begin
      e.dat = beat_val(m, s, k, dw);
      e.lst = (k == l);
      sbq.push_back(e);
    end
    mode  = m;
    len   = 8'(l);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_valid", 64'(mon_valid), 64'd1);
    chk("start_busy", 64'(mon_busy), 64'd1);
  endtask

  // Consumes the queued beats; returns at the done cycle without advancing past it.
  task automatic drain(input int l, input int stall_beat, input int stall_len, input int poke_beat,
                       input logic [63:0] exp_first, input logic [63:0] exp_last);
    sb_t e;
    int beat = 0;
    int stalled = 0;
    int guard = 0;
    while (sbq.size() > 0) begin
      if (guard > l + stall_len + 20) begin
        chk("drain_timeout", 64'(sbq.size()), 64'd0);
        sbq.delete();
        break;
      end
      start = (beat == poke_beat);
      if (beat == stall_beat && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
        chk("stall_valid", 64'(mon_valid), 64'd1);
        chk("stall_data", mon_data, sbq[0].dat);
        chk("stall_last", 64'(mon_last), 64'(sbq[0].lst));
      end else begin
        ready = 1'b1;
        e = sbq.pop_front();
        chk("beat_valid", 64'(mon_valid), 64'd1);
        chk("beat_data", mon_data, e.dat);
        chk("beat_last", 64'(mon_last), 64'(e.lst));
        if (beat == 0) chk("first_data", mon_data, exp_first);
        if (e.lst) chk("last_data", mon_data, exp_last);
        beat++;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("beat_count", 64'(beat), 64'(l + 1));
    chk("end_valid", 64'(mon_valid), 64'd0);
    chk("end_busy", 64'(mon_busy), 64'd0);
    chk("end_done", 64'(mon_done), 64'd1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 2'd0, 3,   64'hDEAD_BEEF, -1, 0, -1, 64'h0001_0203, 64'h0C0D_0E0F};
    vecs[1] = '{0, 2'd1, 2,   64'hFFFF_FFFE,  1, 3, -1, 64'hFFFF_FFFE, 64'h0000_0000};
    vecs[2] = '{1, 2'd2, 15,  64'hA5A5_5A5A, -1, 0,  5, 64'hA5A5_5A5A, 64'hA5A5_5A5A};
    vecs[3] = '{2, 2'd0, 0,   64'h1234_5678, -1, 0, -1, 64'h0001_0203_0405_0607,
                64'h0001_0203_0405_0607};
    vecs[4] = '{0, 2'd0, 255, 64'h0,          7, 2, -1, 64'h0001_0203, 64'hFCFD_FEFF};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_data", mon_data, 64'd0);
      chk("rst_valid", 64'(mon_valid), 64'd0);
      chk("rst_last", 64'(mon_last), 64'd0);
      chk("rst_busy", 64'(mon_busy), 64'd0);
      chk("rst_done", 64'(mon_done), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      sel = vecs[i].sel;
      dw  = (vecs[i].sel == 2) ? 64 : 32;
      do_start(vecs[i].mode, vecs[i].len, vecs[i].seed);
      drain(vecs[i].len, vecs[i].stall_beat, vecs[i].stall_len, vecs[i].poke_beat,
            vecs[i].exp_first, vecs[i].exp_last);
      @(negedge clk);
      chk("done_clear", 64'(mon_done), 64'd0);
    end

    // Toggle burst, then a new start on the done cycle.
    sel = 0;
    dw  = 32;
    do_start(2'd3, 1, 64'h0000_FFFF);
    drain(1, -1, 0, -1, 64'h0000_FFFF, 64'hFFFF_0000);
    do_start(2'd1, 1, 64'h0000_0010);
    drain(1, -1, 0, -1, 64'h0000_0010, 64'h0000_0011);
    @(negedge clk);
    chk("chain_done_clear", 64'(mon_done), 64'd0);

    // Abort on beat 2 of an 8-beat burst, coincident with ready.
    do_start(2'd1, 7, 64'h0000_0100);
    for (int k = 0; k < 2; k++) begin
      chk("abort_pre_data", mon_data, sbq.pop_front().dat);
      @(negedge clk);
    end
    chk("abort_beat2", mon_data, 64'h0000_0102);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sbq.delete();
    chk("abort_valid", 64'(mon_valid), 64'd0);
    chk("abort_last", 64'(mon_last), 64'd0);
    chk("abort_busy", 64'(mon_busy), 64'd0);
    chk("abort_done", 64'(mon_done), 64'd0);
    @(negedge clk);
    chk("abort_done_later", 64'(mon_done), 64'd0);

    // Reset in the middle of a burst.
    do_start(2'd3, 7, 64'h1111_2222);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    chk("mrst_data", mon_data, 64'd0);
    chk("mrst_valid", 64'(mon_valid), 64'd0);
    chk("mrst_last", 64'(mon_last), 64'd0);
    chk("mrst_busy", 64'(mon_busy), 64'd0);
    chk("mrst_done", 64'(mon_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
